// File: rtl/sdram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_req_arbiter
//
// Front-end for a NESTang-style SDRAM controller. Client read/write requests
// arrive over a valid/ready handshake and are turned into the controller's
// single-cycle rd / wr / refresh pulses. A free-running refresh timer
// schedules refreshes, and a due refresh always wins over a client request.
// Read data comes back to the client as a one-cycle rsp_valid pulse.
//
// Optional feature macro: SDRAM_ARB_STATS_EN
//   When defined, the refresh_cnt and debt_cnt statistics outputs exist.
//   When undefined, neither port nor counter is built.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   req_valid/req_ready      client request handshake (req_ready is combinational)
//   req_we/req_addr/req_wdata  request type (1 = write), address, write data
//   rsp_valid/rsp_rdata      one-cycle read response
//   mem_addr/mem_din         address and write data to the controller, held
//                            from the pulse until the FSM is back in IDLE
//   mem_rd/mem_wr/mem_refresh  single-cycle command pulses to the controller
//   mem_dout/mem_data_ready/mem_busy  controller status and read data
//   timeout_err              sticky: an access stayed in WAIT for TIMEOUT cycles
//   refresh_cnt, debt_cnt    (SDRAM_ARB_STATS_EN only) refresh pulses issued,
//                            cycles spent with the refresh timer saturated
// -----------------------------------------------------------------------------
module sdram_req_arbiter #(
    parameter int unsigned FREQ       = 27_000_000,
    parameter int unsigned REFRESH_US = 15,
    parameter int unsigned ADDR_W     = 23,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_refresh,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_data_ready,
    input  logic              mem_busy,
    output logic              timeout_err
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [15:0]       refresh_cnt,
    output logic [15:0]       debt_cnt
`endif
);

    // Refresh interval in cycles; the timer holds at most two intervals of debt.
    localparam int unsigned RCYC = FREQ / 1_000_000 * REFRESH_US;
    localparam int unsigned RMAX = 2 * RCYC;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam int unsigned TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGap  = 2'd1,
        StWait = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     rtime_q, rtime_d;
    logic [TW-1:0]     wcnt_q, wcnt_d;
    logic              rd_op_q, rd_op_d;
    logic              got_q, got_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_refresh_q, mem_refresh_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              timeout_err_q, timeout_err_d;

    logic              refresh_due;
    logic              issue_ref;
    logic [RW-1:0]     rtime_inc;

    assign refresh_due = (rtime_q >= RW'(RCYC));

    // Gated by resetn so that every output reads 0 while reset is held.
    assign req_ready = resetn & (state_q == StIdle) & ~mem_busy & ~refresh_due;

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        rd_op_d       = rd_op_q;
        got_d         = got_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        mem_rd_d      = 1'b0;
        mem_wr_d      = 1'b0;
        mem_refresh_d = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        timeout_err_d = timeout_err_q;
        issue_ref     = 1'b0;

        // Wait counter runs through GAP and WAIT and saturates at TIMEOUT.
        if ((state_q != StIdle) && (wcnt_q != TW'(TIMEOUT))) begin
            wcnt_d = wcnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (refresh_due && !mem_busy) begin
                    issue_ref     = 1'b1;
                    mem_refresh_d = 1'b1;
                    rd_op_d       = 1'b0;
                    got_d         = 1'b0;
                    wcnt_d        = '0;
                    state_d       = StGap;
                end else if (req_valid && req_ready) begin
                    mem_addr_d = req_addr;
                    mem_din_d  = req_wdata;
                    rd_op_d    = ~req_we;
                    mem_wr_d   = req_we;
                    mem_rd_d   = ~req_we;
                    got_d      = 1'b0;
                    wcnt_d     = '0;
                    state_d    = StGap;
                end
            end
            StGap: begin
                // busy from the controller lags the pulse, so it is not looked at here
                state_d = StWait;
            end
            StWait: begin
                if (rd_op_q && mem_data_ready && !got_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_dout;
                    got_d       = 1'b1;
                end
                if (!mem_busy) begin
                    state_d = StIdle;
                end else if (wcnt_q >= TW'(TIMEOUT)) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Refresh timer: saturating increment, minus one interval when a refresh
    // is issued. Issuing requires refresh_due, so the subtraction cannot wrap.
    always_comb begin
        rtime_inc = (rtime_q == RW'(RMAX)) ? rtime_q : rtime_q + 1'b1;
        rtime_d   = issue_ref ? (rtime_inc - RW'(RCYC)) : rtime_inc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            rtime_q       <= '0;
            wcnt_q        <= '0;
            rd_op_q       <= 1'b0;
            got_q         <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_refresh_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rtime_q       <= rtime_d;
            wcnt_q        <= wcnt_d;
            rd_op_q       <= rd_op_d;
            got_q         <= got_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            mem_refresh_q <= mem_refresh_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_refresh = mem_refresh_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign timeout_err = timeout_err_q;

`ifdef SDRAM_ARB_STATS_EN
    logic [15:0] refresh_cnt_q, refresh_cnt_d;
    logic [15:0] debt_cnt_q, debt_cnt_d;

    always_comb begin
        refresh_cnt_d = refresh_cnt_q + (mem_refresh_q ? 16'd1 : 16'd0);
        debt_cnt_d    = debt_cnt_q + ((rtime_q == RW'(RMAX)) ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            refresh_cnt_q <= '0;
            debt_cnt_q    <= '0;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            debt_cnt_q    <= debt_cnt_d;
        end
    end

    assign refresh_cnt = refresh_cnt_q;
    assign debt_cnt    = debt_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_req_arbiter
//
// Directed bench for sdram_req_arbiter with RCYC = 10 and TIMEOUT = 16.
// Controller model: busy high for 4 cycles after any pulse, data_ready one
// cycle wide 3 cycles after rd, with a small 16-entry memory behind it.
// Cycle index k counts negedges since reset release (k = 0 is the release).
// -----------------------------------------------------------------------------
module tb_sdram_req_arbiter;

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_refresh;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_data_ready;
    logic              mem_busy;
    logic              timeout_err;
`ifdef SDRAM_ARB_STATS_EN
    logic [15:0]       refresh_cnt;
    logic [15:0]       debt_cnt;
`endif

    logic force_busy;

    sdram_req_arbiter #(
        .FREQ       (10_000_000),
        .REFRESH_US (1),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT    (16)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_refresh    (mem_refresh),
        .mem_dout       (mem_dout),
        .mem_data_ready (mem_data_ready),
        .mem_busy       (mem_busy),
        .timeout_err    (timeout_err)
`ifdef SDRAM_ARB_STATS_EN
        ,
        .refresh_cnt    (refresh_cnt),
        .debt_cnt       (debt_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Controller model
    logic [7:0] mem_model [16];
    int         bcnt = 0;
    int         dcnt = 0;
    logic [7:0] dout_q = 8'h00;

    always @(posedge clk) begin
        if (mem_wr) mem_model[mem_addr[3:0]] <= mem_din;
        if (mem_rd) dout_q <= mem_model[mem_addr[3:0]];
        if (mem_rd || mem_wr || mem_refresh) bcnt <= 4;
        else if (bcnt != 0) bcnt <= bcnt - 1;
        if (mem_rd) dcnt <= 3;
        else if (dcnt != 0) dcnt <= dcnt - 1;
    end

    assign mem_busy       = (bcnt != 0) || force_busy;
    assign mem_data_ready = (dcnt == 1);
    assign mem_dout       = dout_q;

    // Pulse monitor: counts, plus overlap / adjacency violations
    int   n_rd = 0, n_wr = 0, n_ref = 0, n_rsp = 0, n_bad = 0;
    logic prev_pulse = 1'b0;

    always @(posedge clk) begin
        if (mem_rd) n_rd <= n_rd + 1;
        if (mem_wr) n_wr <= n_wr + 1;
        if (mem_refresh) n_ref <= n_ref + 1;
        if (rsp_valid) n_rsp <= n_rsp + 1;
        if ((int'(mem_rd) + int'(mem_wr) + int'(mem_refresh)) > 1) n_bad <= n_bad + 1;
        if (prev_pulse && (mem_rd || mem_wr || mem_refresh)) n_bad <= n_bad + 1;
        prev_pulse <= mem_rd || mem_wr || mem_refresh;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int ref_base = 0;

    task automatic do_reset();
        resetn     = 1'b0;
        req_valid  = 1'b0;
        force_busy = 1'b0;
        step(6);
        resetn   = 1'b1;
        ref_base = n_ref;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    int   ref_k[$];
    int   base_rd, base_wr, base_rsp;
    logic prev_ready;

    initial begin
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        force_busy = 1'b0;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_ref", mem_refresh, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_err", timeout_err, 0);

        // 1. write 0x000001 = 0xED, then read it back
        do_reset();
        base_wr  = n_wr;
        base_rsp = n_rsp;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 23'h1; req_wdata = 8'hED;
        #1 check("t1_ready0", req_ready, 1);
        step(1); // k=1
        req_valid = 1'b0;
        check("t1_wr", mem_wr, 1);
        check("t1_addr", mem_addr, 1);
        check("t1_din", mem_din, 8'hED);
        for (int k = 2; k <= 6; k++) begin
            step(1);
            check("t1_busy_ready", req_ready, 0);
            check("t1_wr_low", mem_wr, 0);
            check("t1_addr_held", mem_addr, 1);
        end
        step(1); // k=7
        check("t1_ready7", req_ready, 1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 23'h1;
        step(1); // k=8
        req_valid = 1'b0;
        check("t1_rd", mem_rd, 1);
        check("t1_rd_addr", mem_addr, 1);
        step(3); // k=11
        check("t1_rsp_early", rsp_valid, 0);
        step(1); // k=12
        check("t1_rsp", rsp_valid, 1);
        check("t1_rdata", rsp_rdata, 8'hED);
        step(1); // k=13
        check("t1_rsp_once", rsp_valid, 0);
        step(3);
        check("t1_wr_count", n_wr - base_wr, 1);
        check("t1_rsp_count", n_rsp - base_rsp, 1);

        // 2. idle: refresh every 10 cycles, req_ready low the cycle before
        do_reset();
        ref_k.delete();
        prev_ready = req_ready;
        for (int k = 1; k <= 45; k++) begin
            step(1);
            if (mem_refresh) begin
                ref_k.push_back(k);
                check("t2_ready_low", prev_ready, 0);
            end
            prev_ready = req_ready;
        end
        check("t2_count", ref_k.size(), 4);
        if (ref_k.size() == 4) begin
            check("t2_ref0", ref_k[0], 11);
            check("t2_ref1", ref_k[1], 21);
            check("t2_ref2", ref_k[2], 31);
            check("t2_ref3", ref_k[3], 41);
        end

        // 3. request presented as refresh becomes due: refresh first
        do_reset();
        base_rd = n_rd;
        step(10); // k=10
        req_valid = 1'b1; req_we = 1'b0; req_addr = 23'h1;
        #1 check("t3_ready_due", req_ready, 0);
        step(1); // k=11
        check("t3_ref", mem_refresh, 1);
        check("t3_no_rd", mem_rd, 0);
        for (int k = 12; k <= 16; k++) begin
            step(1);
            check("t3_hold_ready", req_ready, 0);
        end
        step(1); // k=17
        check("t3_ready17", req_ready, 1);
        step(1); // k=18
        req_valid = 1'b0;
        check("t3_rd", mem_rd, 1);
        check("t3_rd_count", n_rd - base_rd, 0);
        step(4); // k=22
        check("t3_rsp", rsp_valid, 1);
        check("t3_rdata", rsp_rdata, 8'hED);

        // 4. busy held 40 cycles: timer saturates, two refreshes on release
        do_reset();
        force_busy = 1'b1;
        step(30);
        check("t4_sat30", dut.rtime_q, 20);
        step(10); // k=40
        check("t4_sat40", dut.rtime_q, 20);
        check("t4_no_ref", n_ref - ref_base, 0);
        check("t4_ready_low", req_ready, 0);
        force_busy = 1'b0;
        ref_k.delete();
        for (int k = 41; k <= 54; k++) begin
            step(1);
            if (mem_refresh) ref_k.push_back(k);
        end
        check("t4_count", ref_k.size(), 2);
        if (ref_k.size() == 2) begin
            check("t4_ref0", ref_k[0], 41);
            check("t4_ref1", ref_k[1], 48);
        end

        // 5. reset two cycles after a rd pulse abandons the read
        do_reset();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 23'h1;
        step(1); // k=1
        req_valid = 1'b0;
        check("t5_rd", mem_rd, 1);
        base_rsp = n_rsp;
        step(2); // k=3
        resetn = 1'b0;
        #1;
        check("t5_ready", req_ready, 0);
        check("t5_rd0", mem_rd, 0);
        check("t5_addr0", mem_addr, 0);
        check("t5_rsp0", rsp_valid, 0);
        step(2);
        resetn = 1'b1;
        step(10);
        check("t5_no_rsp", n_rsp - base_rsp, 0);

        // 6. busy stuck after a write: timeout after 16 WAIT cycles
        do_reset();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 23'h2; req_wdata = 8'h5A;
        step(1); // k=1
        req_valid = 1'b0;
        check("t6_wr", mem_wr, 1);
        force_busy = 1'b1;
        step(16); // k=17
        check("t6_err_before", timeout_err, 0);
        step(1); // k=18
        check("t6_err", timeout_err, 1);
        check("t6_idle", dut.state_q, 0);
        step(2);
        force_busy = 1'b0;
        step(20);
        check("t6_sticky", timeout_err, 1);
`ifdef SDRAM_ARB_STATS_EN
        check("t6_refresh_cnt", refresh_cnt, n_ref - ref_base);
`endif

        check("pulse_rules", n_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
